lane_spawner: RTL and testbench
===============================

Name: lane_spawner

Overview:
- Consumer of the pseudo-random generator's lane value (`small_data`, 1..4) and raw 32-bit word.
- Schedules game-object spawns: a down-counting period timer expires, the block samples a random lane, rejects lanes that are busy, and issues one spawn over a valid/ready handshake to the game-state logic.
- Sits between the random generator and the lane/object controller.

Parameters:
- PERIOD_W, 26, width of the spawn period timer.
- BASE_PERIOD, 25_000_000, cycles between spawns at level 0; must be ≥ 4.
- MAX_RETRY, 3, consecutive rejected samples before the spawn slot is dropped.
- JITTER_W, 20, number of low bits of `rand_word` added to the reload value (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  spawning allowed (level).
- level  in  2  difficulty: the reload period is `BASE_PERIOD >> level`.
- rand_lane  in  3  generator `small_data`; valid values 1..4.
- rand_word  in  32  generator `data`; used for jitter.
- lane_busy  in  4  bit i=1 means lane i is occupied.
- spawn_ready  in  1  downstream accepts a spawn.
- spawn_valid  out  1  spawn request pending.
- spawn_lane  out  2  lane index 0..3 (= `rand_lane` − 1).
- spawn_skipped  out  1  one-cycle pulse when a slot is dropped.
- spawn_count  out  16  total accepted spawns; wraps at 16 bits.

Behaviour:
- Reset (reset=0, async): state IDLE, timer 0, retry 0, `spawn_valid` 0, `spawn_lane` 0, `spawn_skipped` 0, `spawn_count` 0. Reset overrides everything, including a pending handshake; the spawn is lost.
- States: IDLE, COUNT, SAMPLE, ISSUE.
- IDLE:
  - Outputs quiet.
  - If `enable`=1: load timer with the reload value, go to COUNT.
- COUNT:
  - Timer decrements by 1 each cycle.
  - When timer==1, go to SAMPLE next cycle, so the period is exactly the reload value in cycles.
  - If `enable`=0: go to IDLE next cycle; the timer value is discarded.
- SAMPLE (one cycle per attempt):
  - Capture `rand_lane`.
  - Accepted when the value is in 1..4 and `lane_busy[rand_lane-1]`==0: register `spawn_lane`, clear retry, go to ISSUE.
  - Values 0 and 5..7 are treated as busy.
  - Rejected: retry+1.
    - If retry reaches MAX_RETRY: pulse `spawn_skipped` for 1 cycle, clear retry, reload timer, go to COUNT.
    - Otherwise remain in SAMPLE; the generator advances every cycle, so each attempt sees a new value.
  - If `enable`=0 while in SAMPLE: go to IDLE, retry cleared, no skip pulse.
- ISSUE:
  - `spawn_valid`=1, with `spawn_lane` held stable until the handshake.
  - Handshake cycle: `spawn_valid` & `spawn_ready`. On that edge:
    - `spawn_count`+1 (wraps FFFF→0000).
    - `spawn_valid`→0.
    - Reload timer, go to COUNT; go to IDLE instead if `enable`=0.
  - `enable` dropping during ISSUE does not withdraw `valid`; the handshake completes first.
  - `spawn_ready` is ignored outside ISSUE.
- Latency: first sample occurs reload cycles after entering COUNT. Earliest `spawn_valid` is 1 cycle after an accepted sample. Minimum spawn-to-spawn interval is reload+2 cycles.
- Reload value:
  - `(BASE_PERIOD >> level)`, computed in PERIOD_W bits.
  - `level` is sampled at the moment of reload only.
  - If the result is < 2, force it to 2.
- `lane_busy` is sampled only in SAMPLE. A lane becoming busy during ISSUE does not cancel the spawn.

Optional Feature:
- Macro: `LANE_SPAWNER_JITTER_EN`.
- Defined: reload = `(BASE_PERIOD >> level) + rand_word[JITTER_W-1:0]`, computed in PERIOD_W+1 bits and saturated to all-ones of PERIOD_W. `rand_word` is sampled on the reload cycle.
- Undefined: reload is as above. `rand_word` is unused (lint waiver) and behaviour is fully deterministic except for lane choice.

Decomposition:
- Package `lane_spawner_pkg`:
  - State encoding (IDLE=0, COUNT=1, SAMPLE=2, ISSUE=3).
  - `NUM_LANES`=4 and `LANE_MIN`=1 / `LANE_MAX`=4 constants.
  - Reload minimum constant (2).
- Sub-module `spawn_period_timer`: loadable PERIOD_W down-counter with `load`, `load_val`, `en`, `expire` (asserted when count==1 and `en`).
- The FSM, retry counter and handshake stay in `lane_spawner`.

Test Plan (bench uses BASE_PERIOD=8, MAX_RETRY=3, feature off unless stated):
1. reset low, then high; `enable`=1, `level`=0, `rand_lane`=2, `lane_busy`=0, `spawn_ready`=1 → SAMPLE 8 cycles after enable; `spawn_valid` for 1 cycle with `spawn_lane`=1; `spawn_count`=1; the next spawn follows 10 cycles later.
2. `spawn_ready`=0 for 5 cycles in ISSUE, while `rand_lane` changes and `lane_busy[1]` rises → `spawn_valid` and `spawn_lane`=1 are held stable; the count increments only on the ready cycle.
3. `lane_busy`=4'b1111 → 3 SAMPLE cycles, then `spawn_skipped` pulses once; no `spawn_valid`; `spawn_count` unchanged; the timer restarts at 8.
4. `rand_lane` sequence 0, 7, 3 with `lane_busy`=0 → the third sample is accepted, `spawn_lane`=2, no skip; then `level`=2 → the next period is 2 cycles; `level`=3 → period forced to 2.
5. `enable` drops mid-COUNT → IDLE, no spawn. `enable` drops in ISSUE with `spawn_ready`=0 → `valid` held; after ready, IDLE. reset low during ISSUE → all outputs 0 immediately (async).
6. `LANE_SPAWNER_JITTER_EN` defined, JITTER_W=4, `rand_word`=32'h0000_0005 at reload → period 13 cycles. Preload `spawn_count`=FFFF via 65535 spawns (or force) → the next spawn wraps to 0000.

Source files
------------

// File: rtl/lane_spawner_pkg.sv
// lane_spawner_pkg: shared types and constants for the lane spawner.
//   state_e      - spawner FSM encoding
//   NUM_LANES    - number of playfield lanes
//   LANE_MIN/MAX - legal range of the generator lane value (1-based)
//   RELOAD_MIN   - smallest period the timer is ever loaded with
package lane_spawner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_ISSUE  = 2'd3
  } state_e;

  localparam int         NUM_LANES  = 4;
  localparam logic [2:0] LANE_MIN   = 3'd1;
  localparam logic [2:0] LANE_MAX   = 3'd4;
  localparam int         RELOAD_MIN = 2;

  function automatic logic lane_in_range(input logic [2:0] lane);
    return (lane >= LANE_MIN) && (lane <= LANE_MAX);
  endfunction

endpackage

// File: rtl/spawn_period_timer.sv
// spawn_period_timer: loadable down-counter for the spawn period.
//   clk_i, rst_ni  - clock, async active-low reset (count -> 0)
//   load_i         - load load_val_i (wins over en_i)
//   load_val_i     - reload value
//   en_i           - decrement by one this cycle
//   expire_o       - count==1 while enabled: last cycle of the period
module spawn_period_timer #(
  parameter int PERIOD_W = 26
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] load_val_i,
  input  logic                en_i,
  output logic                expire_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                               cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)             cnt_d = cnt_q - PERIOD_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == PERIOD_W'(1));

endmodule

// File: rtl/lane_spawner.sv
// lane_spawner: periodic spawn scheduler fed by the random generator.
// A period timer expires, a random lane is sampled (busy / illegal lanes are
// retried up to MAX_RETRY times, then the slot is dropped), and the accepted
// lane is offered downstream over valid/ready.
//   clk_i, rst_ni     - clock, async active-low reset
//   enable_i          - spawning allowed
//   level_i           - difficulty, period = BASE_PERIOD >> level
//   rand_lane_i       - generator lane value, legal 1..4
//   rand_word_i       - generator raw word (jitter source)
//   lane_busy_i       - per-lane occupied flags
//   spawn_ready_i     - downstream accepts
//   spawn_valid_o     - spawn pending
//   spawn_lane_o      - lane index 0..3
//   spawn_skipped_o   - one-cycle pulse when a slot is dropped
//   spawn_count_o     - accepted spawns, wraps at 16 bits
// Optional: define LANE_SPAWNER_JITTER_EN to add rand_word_i[JITTER_W-1:0]
// to every reload (saturating).
module lane_spawner
  import lane_spawner_pkg::*;
#(
  parameter int PERIOD_W    = 26,
  parameter int BASE_PERIOD = 25_000_000,
  parameter int MAX_RETRY   = 3,
  parameter int JITTER_W    = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [1:0]           level_i,
  input  logic [2:0]           rand_lane_i,
  input  logic [31:0]          rand_word_i,
  input  logic [NUM_LANES-1:0] lane_busy_i,
  input  logic                 spawn_ready_i,
  output logic                 spawn_valid_o,
  output logic [1:0]           spawn_lane_o,
  output logic                 spawn_skipped_o,
  output logic [15:0]          spawn_count_o
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  state_e              state_q, state_d;
  logic [RETRY_W-1:0]  retry_q, retry_d, retry_inc;
  logic [1:0]          lane_q, lane_d, lane_sel;
  logic                skip_q, skip_d;
  logic [15:0]         count_q, count_d;
  logic                tmr_load, tmr_en, tmr_expire, lane_ok;
  logic [PERIOD_W-1:0] base_shift, reload_floor, reload_val;

  // Upper generator bits are never needed; fold them so they count as used.
  logic unused_rand;
  assign unused_rand = ^rand_word_i;

  // Reload value, evaluated only on the cycle the timer is loaded.
  assign base_shift   = PERIOD_W'(BASE_PERIOD) >> level_i;
  assign reload_floor = (base_shift < PERIOD_W'(RELOAD_MIN)) ? PERIOD_W'(RELOAD_MIN)
                                                              : base_shift;
`ifdef LANE_SPAWNER_JITTER_EN
  logic [PERIOD_W:0] reload_sum;
  assign reload_sum = {1'b0, reload_floor} + (PERIOD_W+1)'(rand_word_i[JITTER_W-1:0]);
  assign reload_val = reload_sum[PERIOD_W] ? '1 : reload_sum[PERIOD_W-1:0];
`else
  assign reload_val = reload_floor;
`endif

  // 1..4 maps onto 0..3 by taking the low two bits minus one (4 -> 3 wraps).
  assign lane_sel  = rand_lane_i[1:0] - 2'd1;
  assign lane_ok   = lane_in_range(rand_lane_i) && !lane_busy_i[lane_sel];
  assign retry_inc = retry_q + RETRY_W'(1);

  // Kept outside the FSM comb so expire never feeds back into its own enable.
  assign tmr_en = (state_q == ST_COUNT) && enable_i;

  spawn_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (reload_val),
    .en_i       (tmr_en),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    lane_d   = lane_q;
    skip_d   = 1'b0;
    count_d  = count_q;
    tmr_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          tmr_load = 1'b1;
          state_d  = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!enable_i)       state_d = ST_IDLE;
        else if (tmr_expire) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        retry_d = '0;
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (lane_ok) begin
          lane_d  = lane_sel;
          state_d = ST_ISSUE;
        end else if (retry_inc == RETRY_W'(MAX_RETRY)) begin
          skip_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_COUNT;
        end else begin
          retry_d = retry_inc;
        end
      end
      ST_ISSUE: begin
        // enable only matters once the handshake has completed
        if (spawn_ready_i) begin
          count_d = count_q + 16'd1;
          if (enable_i) begin
            tmr_load = 1'b1;
            state_d  = ST_COUNT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      retry_q <= '0;
      lane_q  <= '0;
      skip_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      lane_q  <= lane_d;
      skip_q  <= skip_d;
      count_q <= count_d;
    end
  end

  assign spawn_valid_o   = (state_q == ST_ISSUE);
  assign spawn_lane_o    = lane_q;
  assign spawn_skipped_o = skip_q;
  assign spawn_count_o   = count_q;

endmodule

// File: tb/tb_lane_spawner.sv
module tb_lane_spawner;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic [1:0]  level_i;
  logic [2:0]  rand_lane_i;
  logic [31:0] rand_word_i;
  logic [3:0]  lane_busy_i;
  logic        spawn_ready_i;
  logic        spawn_valid_o;
  logic [1:0]  spawn_lane_o;
  logic        spawn_skipped_o;
  logic [15:0] spawn_count_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  lane_spawner #(
    .PERIOD_W(26), .BASE_PERIOD(8), .MAX_RETRY(3), .JITTER_W(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .level_i(level_i),
    .rand_lane_i(rand_lane_i), .rand_word_i(rand_word_i), .lane_busy_i(lane_busy_i),
    .spawn_ready_i(spawn_ready_i), .spawn_valid_o(spawn_valid_o),
    .spawn_lane_o(spawn_lane_o), .spawn_skipped_o(spawn_skipped_o),
    .spawn_count_o(spawn_count_o)
  );

  typedef struct {
    logic        en;
    logic [1:0]  lvl;
    logic [2:0]  lane;
    logic [3:0]  busy;
    logic        rdy;
    logic        exp_valid;
    logic [1:0]  exp_lane;
    logic        exp_skip;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    enable_i = 1'b0; level_i = 2'd0; rand_lane_i = 3'd2; rand_word_i = 32'd0;
    lane_busy_i = 4'd0; spawn_ready_i = 1'b1;
    repeat (2) tick();
    rst_ni = 1'b1;
  endtask

  // Ticks until spawn_valid is seen; an expired budget is a failed check.
  task automatic wait_valid(input string name, input int budget);
    int cyc = 0;
    while (!spawn_valid_o && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!spawn_valid_o) check({name, " timeout"}, 32'(spawn_valid_o), 32'd1);
  endtask

  initial begin
    // ---- reset state
    do_reset();
    check("rst valid", 32'(spawn_valid_o), 32'd0);
    check("rst lane",  32'(spawn_lane_o),  32'd0);
    check("rst skip",  32'(spawn_skipped_o), 32'd0);
    check("rst count", 32'(spawn_count_o), 32'd0);

    // ---- 1: free-running spawns, period 8 -> SAMPLE at edge 9, valid at 10, 20
    for (int k = 0; k < 21; k++) begin
      vecs[k].en = 1'b1; vecs[k].lvl = 2'd0; vecs[k].lane = 3'd2;
      vecs[k].busy = 4'd0; vecs[k].rdy = 1'b1; vecs[k].exp_skip = 1'b0;
      vecs[k].exp_valid = (k + 1 == 10) || (k + 1 == 20);
      vecs[k].exp_lane  = (k + 1 >= 10) ? 2'd1 : 2'd0;
      vecs[k].exp_count = (k + 1 >= 21) ? 16'd2 : (k + 1 >= 11) ? 16'd1 : 16'd0;
    end
    for (int k = 0; k < 21; k++) begin
      enable_i = vecs[k].en; level_i = vecs[k].lvl; rand_lane_i = vecs[k].lane;
      lane_busy_i = vecs[k].busy; spawn_ready_i = vecs[k].rdy;
      tick();
      check($sformatf("t1 valid e%0d", k + 1), 32'(spawn_valid_o), 32'(vecs[k].exp_valid));
      check($sformatf("t1 lane e%0d", k + 1),  32'(spawn_lane_o),  32'(vecs[k].exp_lane));
      check($sformatf("t1 skip e%0d", k + 1),  32'(spawn_skipped_o), 32'(vecs[k].exp_skip));
      check($sformatf("t1 count e%0d", k + 1), 32'(spawn_count_o), 32'(vecs[k].exp_count));
    end

    // ---- 2: back-pressure holds valid/lane despite lane/busy changes
    do_reset();
    enable_i = 1'b1; spawn_ready_i = 1'b0;
    repeat (10) tick();
    check("t2 valid", 32'(spawn_valid_o), 32'd1);
    check("t2 lane",  32'(spawn_lane_o),  32'd1);
    for (int k = 0; k < 5; k++) begin
      rand_lane_i = 3'(k + 3); lane_busy_i = 4'b0010;
      tick();
      check($sformatf("t2 hold valid %0d", k), 32'(spawn_valid_o), 32'd1);
      check($sformatf("t2 hold lane %0d", k),  32'(spawn_lane_o),  32'd1);
      check($sformatf("t2 hold count %0d", k), 32'(spawn_count_o), 32'd0);
    end
    spawn_ready_i = 1'b1;
    tick();
    check("t2 hs valid", 32'(spawn_valid_o), 32'd0);
    check("t2 hs count", 32'(spawn_count_o), 32'd1);

    // ---- 3: all lanes busy -> skip at edge 12, then again at edge 23
    do_reset();
    enable_i = 1'b1; lane_busy_i = 4'b1111;
    for (int e = 1; e <= 24; e++) begin
      tick();
      check($sformatf("t3 skip e%0d", e), 32'(spawn_skipped_o), 32'(e == 12 || e == 23));
      check($sformatf("t3 valid e%0d", e), 32'(spawn_valid_o), 32'd0);
    end
    check("t3 count", 32'(spawn_count_o), 32'd0);

    // ---- 4: illegal lanes 0, 7 then 3; then level 2 and level 3 periods
    do_reset();
    enable_i = 1'b1; rand_lane_i = 3'd0;
    repeat (9) tick();
    tick();                                 // edge 10: sample 0
    check("t4 e10 valid", 32'(spawn_valid_o), 32'd0);
    rand_lane_i = 3'd7;
    tick();                                 // edge 11: sample 7
    check("t4 e11 skip", 32'(spawn_skipped_o), 32'd0);
    rand_lane_i = 3'd3;
    tick();                                 // edge 12: sample 3 accepted
    check("t4 e12 valid", 32'(spawn_valid_o), 32'd1);
    check("t4 e12 lane",  32'(spawn_lane_o),  32'd2);
    check("t4 e12 skip",  32'(spawn_skipped_o), 32'd0);
    level_i = 2'd2;
    tick();                                 // edge 13: handshake, reload 2
    check("t4 e13 count", 32'(spawn_count_o), 32'd1);
    for (int e = 14; e <= 16; e++) begin
      tick();
      check($sformatf("t4 lvl2 valid e%0d", e), 32'(spawn_valid_o), 32'(e == 16));
    end
    level_i = 2'd3;
    for (int e = 17; e <= 20; e++) begin
      tick();
      check($sformatf("t4 lvl3 valid e%0d", e), 32'(spawn_valid_o), 32'(e == 20));
    end

    // ---- 5a: enable drops mid-COUNT -> no spawn; re-enable restarts period
    do_reset();
    enable_i = 1'b1;
    repeat (4) tick();
    enable_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("t5a idle valid %0d", k), 32'(spawn_valid_o), 32'd0);
    end
    check("t5a count", 32'(spawn_count_o), 32'd0);
    // ---- 5b: enable drops in ISSUE while stalled
    enable_i = 1'b1; spawn_ready_i = 1'b0;
    repeat (9) tick();
    check("t5b e9 valid", 32'(spawn_valid_o), 32'd0);
    tick();
    check("t5b e10 valid", 32'(spawn_valid_o), 32'd1);
    enable_i = 1'b0;
    repeat (3) tick();
    check("t5b held valid", 32'(spawn_valid_o), 32'd1);
    spawn_ready_i = 1'b1;
    tick();
    check("t5b hs valid", 32'(spawn_valid_o), 32'd0);
    check("t5b hs count", 32'(spawn_count_o), 32'd1);
    repeat (15) tick();
    check("t5b idle valid", 32'(spawn_valid_o), 32'd0);
    check("t5b idle count", 32'(spawn_count_o), 32'd1);
    // ---- 5c: async reset during ISSUE
    enable_i = 1'b1; spawn_ready_i = 1'b0;
    wait_valid("t5c", 20);
    check("t5c pre lane", 32'(spawn_lane_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("t5c rst valid", 32'(spawn_valid_o), 32'd0);
    check("t5c rst lane",  32'(spawn_lane_o),  32'd0);
    check("t5c rst count", 32'(spawn_count_o), 32'd0);

    // ---- 6: jitter on reload, then count wrap
    do_reset();
    enable_i = 1'b1; rand_word_i = 32'h0000_0005;
`ifdef LANE_SPAWNER_JITTER_EN
    repeat (14) tick();
    check("t6 jit e14 valid", 32'(spawn_valid_o), 32'd0);
    tick();
    check("t6 jit e15 valid", 32'(spawn_valid_o), 32'd1);
`else
    repeat (9) tick();
    check("t6 nojit e9 valid", 32'(spawn_valid_o), 32'd0);
    tick();
    check("t6 nojit e10 valid", 32'(spawn_valid_o), 32'd1);
`endif
    tick();
    check("t6 count1", 32'(spawn_count_o), 32'd1);
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    tick();
    check("t6 preload", 32'(spawn_count_o), 32'hFFFF);
    wait_valid("t6 wrap", 40);
    tick();
    check("t6 wrap count", 32'(spawn_count_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
